// File: rtl/video_timing_pkg.sv
// Shared constants for the video raster timing generator.
// Holds the coordinate width, the counter range limit and the standard
// CEA presets (480p, 720p, 1080p), plus a helper that sums a line/frame span.
package video_timing_pkg;

    // Coordinate / counter width; both raster totals must fit in it.
    localparam int COORD_W   = 12;
    localparam int MAX_TOTAL = 1 << COORD_W;

    // 640x480 @ 60 Hz, negative syncs
    localparam int P480_H_ACTIVE = 640;
    localparam int P480_H_FP     = 16;
    localparam int P480_H_SYNC   = 96;
    localparam int P480_H_BP     = 48;
    localparam int P480_V_ACTIVE = 480;
    localparam int P480_V_FP     = 10;
    localparam int P480_V_SYNC   = 2;
    localparam int P480_V_BP     = 33;
    localparam bit P480_HS_POL   = 1'b0;
    localparam bit P480_VS_POL   = 1'b0;

    // 1280x720 @ 60 Hz, positive syncs
    localparam int P720_H_ACTIVE = 1280;
    localparam int P720_H_FP     = 110;
    localparam int P720_H_SYNC   = 40;
    localparam int P720_H_BP     = 220;
    localparam int P720_V_ACTIVE = 720;
    localparam int P720_V_FP     = 5;
    localparam int P720_V_SYNC   = 5;
    localparam int P720_V_BP     = 20;
    localparam bit P720_HS_POL   = 1'b1;
    localparam bit P720_VS_POL   = 1'b1;

    // 1920x1080 @ 60 Hz, positive syncs
    localparam int P1080_H_ACTIVE = 1920;
    localparam int P1080_H_FP     = 88;
    localparam int P1080_H_SYNC   = 44;
    localparam int P1080_H_BP     = 148;
    localparam int P1080_V_ACTIVE = 1080;
    localparam int P1080_V_FP     = 4;
    localparam int P1080_V_SYNC   = 5;
    localparam int P1080_V_BP     = 36;
    localparam bit P1080_HS_POL   = 1'b1;
    localparam bit P1080_VS_POL   = 1'b1;

    // Total length of a line (in pixels) or frame (in lines).
    function automatic int span_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Purpose : raster timing (hs/vs/de, active coordinates, frame_start) from free-running line/frame counters.
// Latency : outputs registered, 1 cycle after the counter state they decode; all outputs mutually aligned.
// Backpr. : none; free-running at the pixel clock, timing_en low parks the raster at (0,0) with idle outputs.
//
// Ports:
//   video_clk    pixel clock
//   rst_n        asynchronous active-low reset
//   timing_en    run enable; low forces counters to origin and outputs to idle
//   video_hs/vs  horizontal / vertical sync at HS_POL / VS_POL asserted level
//   video_de     data enable, high in the active region
//   active_x/y   pixel column / row while video_de, 0 otherwise
//   frame_start  one-cycle pulse on the first active pixel of each frame
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = P720_H_ACTIVE,
    parameter int H_FP     = P720_H_FP,
    parameter int H_SYNC   = P720_H_SYNC,
    parameter int H_BP     = P720_H_BP,
    parameter int V_ACTIVE = P720_V_ACTIVE,
    parameter int V_FP     = P720_V_FP,
    parameter int V_SYNC   = P720_V_SYNC,
    parameter int V_BP     = P720_V_BP,
    parameter bit HS_POL   = P720_HS_POL,
    parameter bit VS_POL   = P720_VS_POL
) (
    input  logic               video_clk,
    input  logic               rst_n,
    input  logic               timing_en,
    output logic               video_hs,
    output logic               video_vs,
    output logic               video_de,
    output logic [COORD_W-1:0] active_x,
    output logic [COORD_W-1:0] active_y,
    output logic               frame_start
);

    // Totals are at most MAX_TOTAL, so the last count always fits in COORD_W bits.
    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

    // Region boundaries are compared one bit wider so that a sync ending
    // exactly at MAX_TOTAL (zero back porch) does not wrap to 0.
    localparam logic [COORD_W:0] H_ACT_END = (COORD_W+1)'(H_ACTIVE);
    localparam logic [COORD_W:0] HS_START  = (COORD_W+1)'(H_ACTIVE + H_FP);
    localparam logic [COORD_W:0] HS_END    = (COORD_W+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W:0] V_ACT_END = (COORD_W+1)'(V_ACTIVE);
    localparam logic [COORD_W:0] VS_START  = (COORD_W+1)'(V_ACTIVE + V_FP);
    localparam logic [COORD_W:0] VS_END    = (COORD_W+1)'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;

    logic [COORD_W:0]   h_ext;
    logic [COORD_W:0]   v_ext;
    logic               h_act;
    logic               v_act;
    logic               de_nxt;
    logic               hs_nxt;
    logic               vs_nxt;
    logic               fs_nxt;

    // ------------------------------------------------------------------
    // Line / frame counters. v_cnt steps only on the h_cnt wrap, so vsync
    // decoded from it changes on whole-line boundaries.
    // ------------------------------------------------------------------
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!timing_en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Decode of the current counter state. Gating with timing_en makes the
    // disable take effect on the outputs at the same edge that parks the
    // counters, so no stale pixel follows a drop of timing_en.
    // ------------------------------------------------------------------
    always_comb begin
        h_ext  = {1'b0, h_cnt};
        v_ext  = {1'b0, v_cnt};
        h_act  = (h_ext < H_ACT_END);
        v_act  = (v_ext < V_ACT_END);
        de_nxt = timing_en && h_act && v_act;
        hs_nxt = ~HS_POL;
        vs_nxt = ~VS_POL;
        if (timing_en && (h_ext >= HS_START) && (h_ext < HS_END)) begin
            hs_nxt = HS_POL;
        end
        if (timing_en && (v_ext >= VS_START) && (v_ext < VS_END)) begin
            vs_nxt = VS_POL;
        end
        fs_nxt = de_nxt && (h_cnt == '0) && (v_cnt == '0);
    end

    // ------------------------------------------------------------------
    // Output register: everything leaves from flops on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            video_hs    <= ~HS_POL;
            video_vs    <= ~VS_POL;
            video_de    <= 1'b0;
            active_x    <= '0;
            active_y    <= '0;
            frame_start <= 1'b0;
        end else begin
            video_hs    <= hs_nxt;
            video_vs    <= vs_nxt;
            video_de    <= de_nxt;
            active_x    <= de_nxt ? h_cnt : '0;
            active_y    <= de_nxt ? v_cnt : '0;
            frame_start <= fs_nxt;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small raster (H 8/2/2/2, V 4/1/1/1) at both
// sync polarities, plus the default 720p build for line-level checks.
module tb_video_timing_gen;
    import video_timing_pkg::*;

    logic video_clk = 1'b0;
    logic rst_n;
    logic timing_en;

    logic               a_hs, a_vs, a_de, a_fs;
    logic [COORD_W-1:0] a_x, a_y;
    logic               b_hs, b_vs, b_de, b_fs;
    logic [COORD_W-1:0] b_x, b_y;
    logic               c_hs, c_vs, c_de, c_fs;
    logic [COORD_W-1:0] c_x, c_y;

    int n_cmp = 0;
    int n_err = 0;

    always #5 video_clk = ~video_clk;

    // Small raster, positive syncs
    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_dut_a (
        .video_clk(video_clk), .rst_n(rst_n), .timing_en(timing_en),
        .video_hs(a_hs), .video_vs(a_vs), .video_de(a_de),
        .active_x(a_x), .active_y(a_y), .frame_start(a_fs)
    );

    // Small raster, negative syncs
    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_dut_b (
        .video_clk(video_clk), .rst_n(rst_n), .timing_en(timing_en),
        .video_hs(b_hs), .video_vs(b_vs), .video_de(b_de),
        .active_x(b_x), .active_y(b_y), .frame_start(b_fs)
    );

    // Default 720p
    video_timing_gen u_dut_c (
        .video_clk(video_clk), .rst_n(rst_n), .timing_en(timing_en),
        .video_hs(c_hs), .video_vs(c_vs), .video_de(c_de),
        .active_x(c_x), .active_y(c_y), .frame_start(c_fs)
    );

    typedef struct packed {
        logic               hs;
        logic               vs;
        logic               de;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               fs;
    } obs_t;

    localparam int NCAP = 200;
    obs_t cap_a[NCAP];
    obs_t cap_b[NCAP];

    // Expected small-raster outputs at sample n (n = 0 is the first sample
    // after reset release): h = n % 14, v = (n / 14) % 7.
    typedef struct {
        int   n;
        logic hs;
        logic vs;
        logic de;
        int   x;
        int   y;
        logic fs;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge video_clk);
        #1;
    endtask

    initial begin
        int de_cnt, hs_cnt, vs_cnt, fs_cnt, runs, bad_runs, run_len, vs_bad;
        int b_hs_low, b_vs_low;
        int c_de0, c_de1, c_hs0, c_hs_first, c_xmax, c_vs_cnt, c_fs_cnt, c_ybad;
        obs_t o;
        obs_t ob;

        //          n   hs    vs    de    x  y  fs
        vecs[0]  = '{0,   1'b0, 1'b0, 1'b1, 0, 0, 1'b1};
        vecs[1]  = '{3,   1'b0, 1'b0, 1'b1, 3, 0, 1'b0};
        vecs[2]  = '{7,   1'b0, 1'b0, 1'b1, 7, 0, 1'b0};
        vecs[3]  = '{8,   1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
        vecs[4]  = '{9,   1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
        vecs[5]  = '{10,  1'b1, 1'b0, 1'b0, 0, 0, 1'b0};
        vecs[6]  = '{11,  1'b1, 1'b0, 1'b0, 0, 0, 1'b0};
        vecs[7]  = '{12,  1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
        vecs[8]  = '{13,  1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
        vecs[9]  = '{14,  1'b0, 1'b0, 1'b1, 0, 1, 1'b0};
        vecs[10] = '{32,  1'b0, 1'b0, 1'b1, 4, 2, 1'b0};
        vecs[11] = '{49,  1'b0, 1'b0, 1'b1, 7, 3, 1'b0};
        vecs[12] = '{56,  1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
        vecs[13] = '{69,  1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
        vecs[14] = '{70,  1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
        vecs[15] = '{80,  1'b1, 1'b1, 1'b0, 0, 0, 1'b0};
        vecs[16] = '{83,  1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
        vecs[17] = '{84,  1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
        vecs[18] = '{97,  1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
        vecs[19] = '{98,  1'b0, 1'b0, 1'b1, 0, 0, 1'b1};
        vecs[20] = '{108, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0};

        // ---------------- reset values ----------------
        rst_n     = 1'b0;
        timing_en = 1'b1;
        repeat (3) tick();
        chk("rst a_hs", a_hs, 0);
        chk("rst a_vs", a_vs, 0);
        chk("rst a_de", a_de, 0);
        chk("rst a_x", a_x, 0);
        chk("rst a_y", a_y, 0);
        chk("rst a_fs", a_fs, 0);
        chk("rst b_hs", b_hs, 1);
        chk("rst b_vs", b_vs, 1);
        chk("rst c_hs", c_hs, 0);
        chk("rst c_de", c_de, 0);

        // ---------------- capture two small frames ----------------
        rst_n = 1'b1;
        for (int n = 0; n < NCAP; n++) begin
            tick();
            cap_a[n] = {a_hs, a_vs, a_de, a_x, a_y, a_fs};
            cap_b[n] = {b_hs, b_vs, b_de, b_x, b_y, b_fs};
        end

        for (int i = 0; i < NV; i++) begin
            o  = cap_a[vecs[i].n];
            ob = cap_b[vecs[i].n];
            chk($sformatf("vec n=%0d a_hs", vecs[i].n), o.hs, vecs[i].hs);
            chk($sformatf("vec n=%0d a_vs", vecs[i].n), o.vs, vecs[i].vs);
            chk($sformatf("vec n=%0d a_de", vecs[i].n), o.de, vecs[i].de);
            chk($sformatf("vec n=%0d a_x", vecs[i].n), o.x, vecs[i].x);
            chk($sformatf("vec n=%0d a_y", vecs[i].n), o.y, vecs[i].y);
            chk($sformatf("vec n=%0d a_fs", vecs[i].n), o.fs, vecs[i].fs);
            chk($sformatf("vec n=%0d b_hs", vecs[i].n), ob.hs, !vecs[i].hs);
            chk($sformatf("vec n=%0d b_vs", vecs[i].n), ob.vs, !vecs[i].vs);
            chk($sformatf("vec n=%0d b_de", vecs[i].n), ob.de, vecs[i].de);
        end

        // Frame-level statistics over the first frame (98 cycles)
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0; runs = 0; bad_runs = 0; run_len = 0;
        b_hs_low = 0; b_vs_low = 0;
        for (int n = 0; n < 98; n++) begin
            if (cap_a[n].de) begin
                de_cnt++;
                run_len++;
            end else if (run_len != 0) begin
                runs++;
                if (run_len != 8) bad_runs++;
                run_len = 0;
            end
            if (cap_a[n].hs) hs_cnt++;
            if (cap_a[n].vs) vs_cnt++;
            if (!cap_b[n].hs) b_hs_low++;
            if (!cap_b[n].vs) b_vs_low++;
        end
        chk("frame de cycles", de_cnt, 32);
        chk("frame de runs", runs, 4);
        chk("de runs not 8 long", bad_runs, 0);
        chk("frame hs cycles", hs_cnt, 14);
        chk("frame vs cycles", vs_cnt, 14);
        chk("frame b_hs low cycles", b_hs_low, 14);
        chk("frame b_vs low cycles", b_vs_low, 14);

        fs_cnt = 0; vs_bad = 0;
        for (int n = 0; n < 196; n++) begin
            if (cap_a[n].fs) fs_cnt++;
            if (n > 0 && cap_a[n].vs != cap_a[n-1].vs && (n % 14) != 0) vs_bad++;
        end
        chk("frame_start pulses in 196 cycles", fs_cnt, 2);
        chk("vs edges off line start", vs_bad, 0);

        // ---------------- reset asserted mid-line ----------------
        // Last capture was n=199: h=3, v=0 -> de high.
        chk("pre-reset a_de", a_de, 1);
        chk("pre-reset a_x", a_x, 3);
        rst_n = 1'b0;
        #1;
        chk("async rst a_de", a_de, 0);
        chk("async rst a_x", a_x, 0);
        chk("async rst a_hs", a_hs, 0);
        chk("async rst b_hs", b_hs, 1);
        chk("async rst b_vs", b_vs, 1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post-rst first de", a_de, 1);
        chk("post-rst first y", a_y, 0);
        chk("post-rst first x", a_x, 0);
        chk("post-rst frame_start", a_fs, 1);

        // ---------------- timing_en drop at (4,2) ----------------
        for (int n = 1; n <= 32; n++) tick();
        chk("pre-drop a_de", a_de, 1);
        chk("pre-drop a_x", a_x, 4);
        chk("pre-drop a_y", a_y, 2);
        timing_en = 1'b0;
        tick();
        chk("drop a_de", a_de, 0);
        chk("drop a_x", a_x, 0);
        chk("drop a_y", a_y, 0);
        chk("drop a_hs", a_hs, 0);
        chk("drop b_hs", b_hs, 1);
        repeat (3) tick();
        chk("held a_de", a_de, 0);
        chk("held a_fs", a_fs, 0);
        timing_en = 1'b1;
        tick();
        chk("re-en a_de", a_de, 1);
        chk("re-en a_fs", a_fs, 1);
        chk("re-en a_x", a_x, 0);
        chk("re-en a_y", a_y, 0);
        tick();
        chk("re-en+1 a_x", a_x, 1);
        chk("re-en+1 a_fs", a_fs, 0);

        // ---------------- 720p line checks ----------------
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        c_de0 = 0; c_de1 = 0; c_hs0 = 0; c_hs_first = -1; c_xmax = 0;
        c_vs_cnt = 0; c_fs_cnt = 0; c_ybad = 0;
        for (int n = 0; n < 3310; n++) begin
            tick();
            if (n < 1650) begin
                if (c_de) c_de0++;
                if (c_hs) begin
                    c_hs0++;
                    if (c_hs_first < 0) c_hs_first = n;
                end
                if (c_de && int'(c_x) > c_xmax) c_xmax = int'(c_x);
            end else if (n < 3300) begin
                if (c_de) c_de1++;
                if (c_de && c_y != 12'd1) c_ybad++;
            end
            if (n == 1650) begin
                chk("720p line1 start de", c_de, 1);
                chk("720p line1 start x", c_x, 0);
                chk("720p line1 start y", c_y, 1);
            end
            if (c_vs) c_vs_cnt++;
            if (c_fs) c_fs_cnt++;
        end
        chk("720p line0 de cycles", c_de0, 1280);
        chk("720p line1 de cycles", c_de1, 1280);
        chk("720p active_x max", c_xmax, 1279);
        chk("720p hs cycles", c_hs0, 40);
        chk("720p hs first cycle", c_hs_first, 1390);
        chk("720p line1 y wrong", c_ybad, 0);
        chk("720p vs in first lines", c_vs_cnt, 0);
        chk("720p frame_start count", c_fs_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
